// File: rtl/csoc_scan_pkg.sv
// Shared types and defaults for the CSOC scan-chain driver.
//   scan_state_e : driver FSM states
//   scan_tag_t   : {valid, expected-bit} pair carried alongside each shifted bit
package csoc_scan_pkg;

  localparam int unsigned NREGS_DEF  = 1918;
  localparam int unsigned SO_LAT_DEF = 2;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    DRAIN,
    CAPT,
    DONE
  } scan_state_e;

  typedef struct packed {
    logic vld;
    logic exp;
  } scan_tag_t;

endpackage

// File: rtl/csoc_scan_if.sv
// Host-side interface of the scan driver: operation control, the pattern
// valid/ready stream, the captured-bit stream and status.
//   master : host/sequencer side
//   slave  : csoc_scan_driver side
interface csoc_scan_if
  import csoc_scan_pkg::*;
#(
  parameter int unsigned CNT_W = $clog2(NREGS_DEF + 1)
);

  logic             start_i;
  logic             capture_i;
  logic             pat_bit_i;
  logic             exp_bit_i;
  logic             pat_valid_i;
  logic             pat_ready_o;
  logic             cap_bit_o;
  logic             cap_valid_o;
  logic [CNT_W-1:0] err_cnt_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, capture_i, pat_bit_i, exp_bit_i, pat_valid_i,
    input  pat_ready_o, cap_bit_o, cap_valid_o, err_cnt_o, busy_o, done_o
  );

  modport slave (
    input  start_i, capture_i, pat_bit_i, exp_bit_i, pat_valid_i,
    output pat_ready_o, cap_bit_o, cap_valid_o, err_cnt_o, busy_o, done_o
  );

endinterface

// File: rtl/csoc_scan_delay.sv
// Fixed-depth shift pipeline for the {valid, expected} tag of each shifted bit,
// matching the latency from pattern accept to a valid scan-out sample.
//   clk_i, rst_i : clock, async active-high reset
//   tag_i        : tag entering this cycle
//   tag_o        : tag delayed by DEPTH cycles
module csoc_scan_delay
  import csoc_scan_pkg::*;
#(
  parameter int unsigned DEPTH = SO_LAT_DEF
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  scan_tag_t tag_i,
  output scan_tag_t tag_o
);

  scan_tag_t pipe_q [DEPTH];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < int'(DEPTH); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/csoc_scan_driver.sv
// Tester-side scan-chain master: loads NREGS pattern bits from the host stream
// into the chip while unloading the previous chain contents, compares each
// unloaded bit against its expected value and counts mismatches.
//   clk_i, rst_i : clock shared with the chip, async active-high reset
//   host         : control, pattern stream, capture stream, status (slave side)
//   scan_so_i    : chip scan-out
//   scan_se_o    : chip scan enable
//   scan_tm_o    : chip test mode
//   scan_si_o    : chip scan-in
module csoc_scan_driver
  import csoc_scan_pkg::*;
#(
  parameter  int unsigned NREGS  = NREGS_DEF,
  parameter  int unsigned SO_LAT = SO_LAT_DEF,
  localparam int unsigned CNT_W  = $clog2(NREGS + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  csoc_scan_if.slave host,
  input  logic       scan_so_i,
  output logic       scan_se_o,
  output logic       scan_tm_o,
  output logic       scan_si_o
);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             capt_q, capt_d;
  logic             rdy_q, rdy_d;
  logic             se_q, se_d;
  logic             si_q, si_d;
  logic             tm_q, tm_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic      accept;
  scan_tag_t tag_in;
  scan_tag_t tag_out;

  assign accept = host.pat_valid_i & rdy_q;
  assign tag_in = '{vld: accept, exp: host.exp_bit_i};

  // Tag emerges in the cycle the chip presents the matching scan-out bit
  csoc_scan_delay #(.DEPTH(SO_LAT)) u_delay (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tag_i (tag_in),
    .tag_o (tag_out)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cap_q   <= '0;
      err_q   <= '0;
      capt_q  <= 1'b0;
      rdy_q   <= 1'b0;
      se_q    <= 1'b0;
      si_q    <= 1'b0;
      tm_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cap_q   <= cap_d;
      err_q   <= err_d;
      capt_q  <= capt_d;
      rdy_q   <= rdy_d;
      se_q    <= se_d;
      si_q    <= si_d;
      tm_q    <= tm_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, counters and registered outputs
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cap_d   = cap_q;
    err_d   = err_q;
    capt_d  = capt_q;
    se_d    = 1'b0;
    si_d    = si_q;

    // A stall leaves scan enable low, so the chip holds chain and scan-out
    if (accept) begin
      se_d  = 1'b1;
      si_d  = host.pat_bit_i;
      acc_d = acc_q + CNT_W'(1);
    end

    if (tag_out.vld) begin
      cap_d = cap_q + CNT_W'(1);
      if ((scan_so_i != tag_out.exp) && (err_q != {CNT_W{1'b1}})) begin
        err_d = err_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (host.start_i) begin
          state_d = SHIFT;
          acc_d   = '0;
          cap_d   = '0;
          err_d   = '0;
          capt_d  = host.capture_i;
        end
      end
      SHIFT: begin
        if (accept && (acc_q == CNT_W'(NREGS - 1))) state_d = DRAIN;
      end
      // Leave as soon as the final capture is being emitted
      DRAIN: begin
        if (cap_d == CNT_W'(NREGS)) state_d = capt_q ? CAPT : DONE;
      end
      CAPT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rdy_d  = (state_d == SHIFT) && (acc_d < CNT_W'(NREGS));
    tm_d   = (state_d != IDLE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign host.pat_ready_o = rdy_q;
  assign host.cap_valid_o = tag_out.vld;
  assign host.cap_bit_o   = scan_so_i & tag_out.vld;
  assign host.err_cnt_o   = err_q;
  assign host.busy_o      = busy_q;
  assign host.done_o      = done_q;
  assign scan_se_o        = se_q;
  assign scan_si_o        = si_q;
  assign scan_tm_o        = tm_q;

endmodule

// File: tb/tb_csoc_scan_driver.sv
// Bench for csoc_scan_driver with an 8-flop chip model on the scan pins.
module tb_csoc_scan_driver;

  localparam int unsigned N     = 8;
  localparam int unsigned CW    = 4;

  logic clk_i = 1'b0;
  logic rst_i;
  logic scan_so_i, scan_se_o, scan_tm_o, scan_si_o;

  csoc_scan_if #(.CNT_W(CW)) sif ();

  csoc_scan_driver #(.NREGS(N), .SO_LAT(2)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .host      (sif),
    .scan_so_i (scan_so_i),
    .scan_se_o (scan_se_o),
    .scan_tm_o (scan_tm_o),
    .scan_si_o (scan_si_o)
  );

  always #5 clk_i = ~clk_i;

  // Chip: shifts toward chain[0] with a registered scan-out; unaffected by the driver reset
  logic [N-1:0] chain = '0;
  logic         so_q  = 1'b0;
  always_ff @(posedge clk_i) begin
    if (scan_tm_o && scan_se_o) begin
      so_q  <= chain[0];
      chain <= {scan_si_o, chain[N-1:1]};
    end
  end
  assign scan_so_i = so_q;

  int total = 0;
  int bad   = 0;

  // Per-operation observations
  logic [N-1:0] cap_bits;
  int           ncap, se_errs, done_cnt, capt_cycles, last_cap, done_cyc;
  logic [CW-1:0] err_at_done;
  logic         post_tm, post_busy, start_rdy;
  bit           timeout;

  // Operation-level reference: chain content (bit i = chain[i]) before the next operation
  logic [N-1:0] model_chain = '0;

  task automatic run_op(input logic [N-1:0] pat, input logic [N-1:0] exp,
                        input bit capt, input bit stall);
    int idx = 0;
    int cyc = 0;
    bit acc_prev = 1'b0;
    bit fin = 1'b0;
    bit v;
    ncap = 0; se_errs = 0; done_cnt = 0; capt_cycles = 0;
    last_cap = -1; done_cyc = -1; timeout = 1'b0; cap_bits = '0;
    err_at_done = '0; post_tm = 1'bx; post_busy = 1'bx;
    sif.start_i = 1'b1; sif.capture_i = capt;
    sif.pat_valid_i = 1'b1; sif.pat_bit_i = pat[0]; sif.exp_bit_i = exp[0];
    start_rdy = sif.pat_ready_o;
    @(posedge clk_i); #1;
    sif.start_i = 1'b0; sif.capture_i = 1'b0;
    while (!fin) begin
      if (scan_se_o !== acc_prev) se_errs++;
      if (sif.cap_valid_o === 1'b1) begin
        if (ncap < int'(N)) cap_bits[ncap] = sif.cap_bit_o;
        ncap++; last_cap = cyc;
      end
      if (sif.busy_o === 1'b1 && scan_tm_o === 1'b1 && scan_se_o === 1'b0 &&
          sif.cap_valid_o === 1'b0 && sif.done_o === 1'b0 && ncap == int'(N))
        capt_cycles++;
      if (sif.done_o === 1'b1) begin
        done_cnt++; done_cyc = cyc; err_at_done = sif.err_cnt_o;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        post_tm = scan_tm_o; post_busy = sif.busy_o; fin = 1'b1;
      end else if (cyc >= 150) begin
        timeout = 1'b1; fin = 1'b1;
      end
      if (!fin) begin
        v = (idx < int'(N)) && (!stall || $urandom_range(0, 1) == 1);
        sif.pat_valid_i = v;
        sif.pat_bit_i   = (idx < int'(N)) ? pat[idx] : 1'b0;
        sif.exp_bit_i   = (idx < int'(N)) ? exp[idx] : 1'b0;
        sif.start_i     = stall ? 1'($urandom_range(0, 1)) : 1'b0;
        acc_prev = v && (sif.pat_ready_o === 1'b1);
        if (acc_prev) idx++;
        @(posedge clk_i); #1;
        cyc++;
      end
    end
    sif.start_i = 1'b0; sif.pat_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    sif.start_i = 1'b0; sif.capture_i = 1'b0; sif.pat_bit_i = 1'b0;
    sif.exp_bit_i = 1'b0; sif.pat_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    total++;
    if ({sif.pat_ready_o, sif.cap_bit_o, sif.cap_valid_o, sif.err_cnt_o, sif.busy_o,
         sif.done_o, scan_se_o, scan_tm_o, scan_si_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got rdy=%b cap=%b cv=%b err=%0d busy=%b done=%b se=%b tm=%b si=%b, want all 0",
               sif.pat_ready_o, sif.cap_bit_o, sif.cap_valid_o, sif.err_cnt_o, sif.busy_o,
               sif.done_o, scan_se_o, scan_tm_o, scan_si_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_basic();
    logic [N-1:0] want;
    want = model_chain;
    run_op(8'hA5, 8'h00, 1'b0, 1'b0);
    total++;
    if (timeout || ncap != int'(N)) begin
      bad++; $display("FAIL basic_count: got %0d strobes timeout=%0d, want %0d", ncap, timeout, N);
    end
    total++;
    if (cap_bits !== want) begin
      bad++; $display("FAIL basic_data: got %b want %b", cap_bits, want);
    end
    total++;
    if (err_at_done !== CW'($countones(want ^ 8'h00))) begin
      bad++; $display("FAIL basic_err: got %0d want %0d", err_at_done, $countones(want));
    end
    total++;
    if (done_cnt != 1 || done_cyc - last_cap != 1) begin
      bad++; $display("FAIL basic_done: got %0d pulses gap %0d, want 1 pulse gap 1", done_cnt, done_cyc - last_cap);
    end
    total++;
    if (post_tm !== 1'b0 || post_busy !== 1'b0 || se_errs != 0 || start_rdy !== 1'b0) begin
      bad++; $display("FAIL basic_ctrl: got tm=%b busy=%b se_errs=%0d idle_rdy=%b, want 0 0 0 0",
                      post_tm, post_busy, se_errs, start_rdy);
    end
    model_chain = 8'hA5;
  endtask

  task automatic test_pattern(input logic [N-1:0] exp, input string nm);
    logic [N-1:0] want;
    want = model_chain;
    run_op(8'h3C, exp, 1'b0, 1'b0);
    total++;
    if (timeout || ncap != int'(N) || cap_bits !== want) begin
      bad++; $display("FAIL %s_data: got %b (%0d strobes) want %b", nm, cap_bits, ncap, want);
    end
    total++;
    if (err_at_done !== CW'($countones(want ^ exp))) begin
      bad++; $display("FAIL %s_err: got %0d want %0d", nm, err_at_done, $countones(want ^ exp));
    end
    total++;
    if (sif.err_cnt_o !== err_at_done) begin
      bad++; $display("FAIL %s_err_hold: got %0d want %0d", nm, sif.err_cnt_o, err_at_done);
    end
    model_chain = 8'h3C;
  endtask

  task automatic test_stall();
    logic [N-1:0] want, pat, exp;
    for (int k = 0; k < 3; k++) begin
      want = model_chain;
      pat = N'($urandom); exp = N'($urandom);
      run_op(pat, exp, 1'b0, 1'b1);
      total++;
      if (timeout || ncap != int'(N)) begin
        bad++; $display("FAIL stall_count: got %0d strobes timeout=%0d, want %0d", ncap, timeout, N);
      end
      total++;
      if (se_errs != 0) begin
        bad++; $display("FAIL stall_se: got %0d cycles with wrong scan_se_o, want 0", se_errs);
      end
      total++;
      if (cap_bits !== want || err_at_done !== CW'($countones(want ^ exp))) begin
        bad++; $display("FAIL stall_data: got %b err %0d want %b err %0d",
                        cap_bits, err_at_done, want, $countones(want ^ exp));
      end
      model_chain = pat;
    end
  endtask

  task automatic test_capture();
    logic [N-1:0] want, pat;
    want = model_chain;
    pat = N'($urandom);
    run_op(pat, ~want, 1'b1, 1'b0);
    total++;
    if (capt_cycles != 1 || done_cyc - last_cap != 2) begin
      bad++; $display("FAIL capture_cycle: got %0d capture cycles gap %0d, want 1 and 2",
                      capt_cycles, done_cyc - last_cap);
    end
    total++;
    if (cap_bits !== want || err_at_done !== CW'(N) || done_cnt != 1) begin
      bad++; $display("FAIL capture_data: got %b err %0d done %0d want %b err %0d done 1",
                      cap_bits, err_at_done, done_cnt, want, N);
    end
    model_chain = pat;
  endtask

  task automatic test_abort();
    int cnt = 0;
    int guard = 0;
    int dn = 0;
    logic [N-1:0] pat;
    sif.start_i = 1'b1;
    @(posedge clk_i); #1;
    sif.start_i = 1'b0;
    while (cnt < 3 && guard < 50) begin
      sif.pat_valid_i = 1'b1; sif.pat_bit_i = 1'($urandom); sif.exp_bit_i = 1'b0;
      if (sif.pat_ready_o === 1'b1) cnt++;
      @(posedge clk_i); #1;
      guard++;
    end
    sif.pat_valid_i = 1'b0;
    rst_i = 1'b1;
    #1;
    total++;
    if ({sif.pat_ready_o, sif.cap_bit_o, sif.cap_valid_o, sif.err_cnt_o, sif.busy_o,
         sif.done_o, scan_se_o, scan_tm_o, scan_si_o} !== '0 || cnt != 3) begin
      bad++; $display("FAIL abort_outputs: got busy=%b tm=%b se=%b accepts=%0d, want all outputs 0 after 3 accepts",
                      sif.busy_o, scan_tm_o, scan_se_o, cnt);
    end
    repeat (3) begin
      @(posedge clk_i); #1;
      if (sif.done_o !== 1'b0) dn++;
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    if (sif.done_o !== 1'b0) dn++;
    total++;
    if (dn != 0) begin
      bad++; $display("FAIL abort_done: got %0d done cycles, want 0", dn);
    end
    // Chain contents are unknown after the abort; only the operation shape is checked
    pat = N'($urandom);
    run_op(pat, 8'h00, 1'b0, 1'b0);
    total++;
    if (timeout || ncap != int'(N) || done_cnt != 1 || done_cyc - last_cap != 1) begin
      bad++; $display("FAIL abort_rerun: got %0d strobes %0d done gap %0d, want %0d 1 1",
                      ncap, done_cnt, done_cyc - last_cap, N);
    end
    model_chain = pat;
  endtask

  task automatic test_random();
    logic [N-1:0] want, pat, exp;
    bit capt, stall;
    for (int k = 0; k < 5; k++) begin
      want = model_chain;
      pat = N'($urandom); exp = N'($urandom);
      capt = 1'($urandom_range(0, 1)); stall = 1'($urandom_range(0, 1));
      run_op(pat, exp, capt, stall);
      total++;
      if (timeout || ncap != int'(N) || cap_bits !== want) begin
        bad++; $display("FAIL random_data: got %b (%0d strobes) want %b", cap_bits, ncap, want);
      end
      total++;
      if (err_at_done !== CW'($countones(want ^ exp)) || done_cnt != 1 ||
          done_cyc - last_cap != (capt ? 2 : 1) || se_errs != 0) begin
        bad++; $display("FAIL random_status: got err %0d done %0d gap %0d se_errs %0d want err %0d done 1 gap %0d se_errs 0",
                        err_at_done, done_cnt, done_cyc - last_cap, se_errs,
                        $countones(want ^ exp), capt ? 2 : 1);
      end
      model_chain = pat;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pattern(8'hA5, "pattern");
    test_pattern(8'hFF, "mismatch");
    test_stall();
    test_capture();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
